inner_wb_burst_bridge: RTL and testbench
========================================

# inner_wb_burst_bridge

Sits directly downstream of the inner interconnect's `inner_wb_*` master port and upstream of the main wishbone bus. It accepts single, 4-beat and 8-beat burst-tagged requests from the cache/core side and replays them as locked sequences of single-beat wishbone accesses. It generates incrementing, line-wrapping addresses, times out stalled slaves, and returns per-beat ack/err/data upstream.

## Interface
Parameters:
- `ADDR_W`, default `` `WB_ADDR_W ``: word-address width.
- `DATA_W`, default 16: data width.
- `TIMEOUT`, default 255: maximum cycles a downstream beat may wait for ack or err; must be ≥1.

Ports:
- `i_clk`  in  1  clock; all state is on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `u_wb_cyc`, `u_wb_stb`, `u_wb_we`  in  1 each  upstream request.
- `u_wb_adr`  in  ADDR_W  upstream burst base address.
- `u_wb_o_dat`  in  DATA_W  upstream write data.
- `u_wb_sel`  in  2  byte selects.
- `u_wb_4_burst`, `u_wb_8_burst`  in  1 each  burst tags.
- `u_wb_i_dat`  out  DATA_W  read data to upstream.
- `u_wb_ack`, `u_wb_err`  out  1 each  per-beat response.
- `d_wb_cyc`, `d_wb_stb`, `d_wb_we`  out  1 each  downstream master.
- `d_wb_adr`  out  ADDR_W  downstream address.
- `d_wb_o_dat`  out  DATA_W  downstream write data.
- `d_wb_sel`  out  2  downstream byte selects.
- `d_wb_i_dat`  in  DATA_W  downstream read data.
- `d_wb_ack`, `d_wb_err`  in  1 each  downstream response.
- `o_timeout`  out  1  one-cycle pulse when a beat is aborted by timeout.

## Operation
- All outputs are registered.
- Reset value of every output is 0.
- Reset returns the FSM to IDLE and clears all counters.
- Beat count N:
  - `8_burst` = 1 gives N=8; this takes priority when both tags are set.
  - Otherwise `4_burst` = 1 gives N=4.
  - Otherwise N=1.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - On `u_wb_cyc & u_wb_stb`, latch base address, we, sel, data and N.
  - Clear beat counter `beat` (3 bits) and timeout counter; go to ISSUE.
- ISSUE:
  - `d_wb_cyc` = `d_wb_stb` = 1.
  - `d_wb_adr` = `{base[ADDR_W-1:k], base[k-1:0] + beat}` where k = log2(N). Addresses wrap inside the N-aligned line. Example: N=4, base 0x13 gives 0x13, 0x10, 0x11, 0x12.
  - On `d_wb_ack`: latch `d_wb_i_dat`, go to RESP.
  - On `d_wb_err` (ack ignored if both are set): go to ERR handling.
  - On timeout counter reaching TIMEOUT: go to ERR handling.
- RESP:
  - `u_wb_ack` = 1 for exactly one cycle, with `u_wb_i_dat` holding the latched data.
  - `d_wb_stb` = 0 and `d_wb_cyc` stays 1 (bus locked for the whole burst).
  - If `beat == N-1`: drop `d_wb_cyc` and go to IDLE.
  - Otherwise, if `u_wb_cyc & u_wb_stb`: increment `beat`, capture the new `u_wb_o_dat`/`u_wb_sel`, go to ISSUE.
  - Otherwise wait in RESP with `d_wb_cyc` held.
- ERR handling:
  - Pulse `u_wb_err` for one cycle; pulse `o_timeout` as well if the abort was a timeout.
  - Drop `d_wb_cyc`/`d_wb_stb` and go to IDLE.
  - Remaining beats are discarded.
- Upstream `u_wb_cyc` falling in any non-IDLE state:
  - Next cycle, `d_wb_cyc`/`d_wb_stb` = 0 and FSM is IDLE.
  - No upstream ack or err is generated.
  - Any downstream ack arriving that same cycle is ignored.

## Timing
- Request sampled in IDLE at edge t gives `d_wb_stb` high at t+1.
- Downstream ack at edge m gives `u_wb_ack` at m+1.
- The next beat's `d_wb_stb` is high at m+2 (one bubble per beat).
- Zero-wait slave:
  - 8-beat burst completes in 1 + 8×2 = 17 cycles.
  - Single beat completes in 3 cycles.
- Timeout counter:
  - Counts cycles in ISSUE; clears on each new beat.
  - Abort occurs on the cycle the counter equals TIMEOUT.
  - `u_wb_err` is asserted TIMEOUT+1 cycles after the beat's `d_wb_stb` rose.
- Back-to-back requests: one IDLE cycle minimum between transactions.

## Structure
- Burst-length encoding (N from tags) and the TIMEOUT default belong in shared `config.v` as `` `define ``s, alongside `` `WB_ADDR_W ``.
- One natural sub-module: `wb_timeout_cnt` (saturating counter with clear, enable and `expired` output), reused by other bus masters.
- The FSM, beat counter and address wrap logic live in the top module.

## Test plan
- Single read, base 0x000100, slave acks after 2 wait cycles returning 0xBEEF → exactly one `u_wb_ack` with `u_wb_i_dat` = 0xBEEF; `d_wb_cyc` low afterwards.
- 4-beat read, base 0x000013 → `d_wb_adr` sequence 0x13, 0x10, 0x11, 0x12; four upstream acks; `d_wb_cyc` continuously high across the burst.
- 8-beat write with both tags set, data 0x1000 + i → 8 downstream beats carrying 0x1000..0x1007 in order; `d_wb_we` = 1 on every beat.
- Slave never acks, TIMEOUT = 4 → `u_wb_err` and `o_timeout` pulse 5 cycles after `d_wb_stb` rose; FSM returns to IDLE; a new request is accepted afterwards.
- `d_wb_err` on beat 2 of a 4-beat burst → two upstream acks, then one `u_wb_err`; no further downstream beats.
- Upstream drops `u_wb_cyc` mid-burst, and separately `i_rst` is asserted low during ISSUE → all outputs 0 immediately (reset) or next cycle (cyc drop); no spurious upstream ack.

Source files
------------

// File: rtl/inner_wb_burst_bridge_pkg.sv
// +--------------------------------------------------------------------------+
// | inner_wb_burst_bridge_pkg: shared bus defaults and FSM state encoding.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

`ifndef WB_TIMEOUT_DEFAULT
`define WB_TIMEOUT_DEFAULT 255
`endif

// Burst tags to (beat count - 1); the 8-beat tag wins when both are set.
`ifndef WB_BURST_LAST
`define WB_BURST_LAST(tag4, tag8) ((tag8) ? 3'd7 : ((tag4) ? 3'd3 : 3'd0))
`endif

package inner_wb_burst_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic [2:0] burst_last(input logic tag4, input logic tag8);
    return `WB_BURST_LAST(tag4, tag8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
// +--------------------------------------------------------------------------+
// | wb_timeout_cnt: saturating wait counter with clear/enable and expiry.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int c_cnt_w = $clog2(LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == c_limit);

endmodule

`default_nettype wire

// File: rtl/inner_wb_burst_bridge.sv
// +--------------------------------------------------------------------------+
// | inner_wb_burst_bridge: replays tagged bursts as locked single-beat        |
// | wishbone accesses with wrapping addresses and per-beat timeout. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module inner_wb_burst_bridge
  import inner_wb_burst_bridge_pkg::*;
#(
  parameter int ADDR_W  = `WB_ADDR_W,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = `WB_TIMEOUT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              u_wb_cyc,
  input  logic              u_wb_stb,
  input  logic              u_wb_we,
  input  logic [ADDR_W-1:0] u_wb_adr,
  input  logic [DATA_W-1:0] u_wb_o_dat,
  input  logic [1:0]        u_wb_sel,
  input  logic              u_wb_4_burst,
  input  logic              u_wb_8_burst,
  output logic [DATA_W-1:0] u_wb_i_dat,
  output logic              u_wb_ack,
  output logic              u_wb_err,
  output logic              d_wb_cyc,
  output logic              d_wb_stb,
  output logic              d_wb_we,
  output logic [ADDR_W-1:0] d_wb_adr,
  output logic [DATA_W-1:0] d_wb_o_dat,
  output logic [1:0]        d_wb_sel,
  input  logic [DATA_W-1:0] d_wb_i_dat,
  input  logic              d_wb_ack,
  input  logic              d_wb_err,
  output logic              o_timeout
);

  state_e              r_state, w_state;
  logic [2:0]          r_beat, w_beat, r_last, w_last, w_beat_inc;
  logic [ADDR_W-1:0]   r_base, w_base, w_mask, w_wrap_adr;
  logic                w_d_cyc, w_d_stb, w_d_we;
  logic [ADDR_W-1:0]   w_d_adr;
  logic [DATA_W-1:0]   w_d_dat, w_u_dat;
  logic [1:0]          w_d_sel;
  logic                w_u_ack, w_u_err, w_tmo, w_expired;

  wb_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .clr     (r_state != ST_ISSUE),
    .en      (r_state == ST_ISSUE),
    .expired (w_expired)
  );

  // Next beat address stays inside the N-aligned line; r_last doubles as the wrap mask.
  assign w_beat_inc = r_beat + 3'd1;
  assign w_mask     = ADDR_W'(r_last);
  assign w_wrap_adr = (r_base & ~w_mask) | ((r_base + ADDR_W'(w_beat_inc)) & w_mask);

  always_comb begin
    w_state = r_state;
    w_beat  = r_beat;
    w_last  = r_last;
    w_base  = r_base;
    w_d_cyc = d_wb_cyc;
    w_d_stb = d_wb_stb;
    w_d_we  = d_wb_we;
    w_d_adr = d_wb_adr;
    w_d_dat = d_wb_o_dat;
    w_d_sel = d_wb_sel;
    w_u_dat = u_wb_i_dat;
    w_u_ack = 1'b0;
    w_u_err = 1'b0;
    w_tmo   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_d_cyc = 1'b0;
        w_d_stb = 1'b0;
        if (u_wb_cyc && u_wb_stb) begin
          w_base  = u_wb_adr;
          w_last  = burst_last(u_wb_4_burst, u_wb_8_burst);
          w_beat  = 3'd0;
          w_d_we  = u_wb_we;
          w_d_adr = u_wb_adr;
          w_d_dat = u_wb_o_dat;
          w_d_sel = u_wb_sel;
          w_d_cyc = 1'b1;
          w_d_stb = 1'b1;
          w_state = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // An upstream abandon outranks any response landing the same cycle.
        if (!u_wb_cyc) begin
          w_d_cyc = 1'b0;
          w_d_stb = 1'b0;
          w_state = ST_IDLE;
        end else if (d_wb_err) begin
          w_u_err = 1'b1;
          w_d_cyc = 1'b0;
          w_d_stb = 1'b0;
          w_state = ST_IDLE;
        end else if (d_wb_ack) begin
          w_u_dat = d_wb_i_dat;
          w_u_ack = 1'b1;
          w_d_stb = 1'b0;
          w_state = ST_RESP;
        end else if (w_expired) begin
          w_u_err = 1'b1;
          w_tmo   = 1'b1;
          w_d_cyc = 1'b0;
          w_d_stb = 1'b0;
          w_state = ST_IDLE;
        end
      end

      ST_RESP: begin
        if (!u_wb_cyc || (r_beat == r_last)) begin
          w_d_cyc = 1'b0;
          w_d_stb = 1'b0;
          w_state = ST_IDLE;
        end else if (u_wb_stb) begin
          w_beat  = w_beat_inc;
          w_d_adr = w_wrap_adr;
          w_d_dat = u_wb_o_dat;
          w_d_sel = u_wb_sel;
          w_d_stb = 1'b1;
          w_state = ST_ISSUE;
        end
      end

      default: begin
        w_d_cyc = 1'b0;
        w_d_stb = 1'b0;
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_beat     <= 3'd0;
      r_last     <= 3'd0;
      r_base     <= '0;
      d_wb_cyc   <= 1'b0;
      d_wb_stb   <= 1'b0;
      d_wb_we    <= 1'b0;
      d_wb_adr   <= '0;
      d_wb_o_dat <= '0;
      d_wb_sel   <= 2'b00;
      u_wb_i_dat <= '0;
      u_wb_ack   <= 1'b0;
      u_wb_err   <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_beat     <= w_beat;
      r_last     <= w_last;
      r_base     <= w_base;
      d_wb_cyc   <= w_d_cyc;
      d_wb_stb   <= w_d_stb;
      d_wb_we    <= w_d_we;
      d_wb_adr   <= w_d_adr;
      d_wb_o_dat <= w_d_dat;
      d_wb_sel   <= w_d_sel;
      u_wb_i_dat <= w_u_dat;
      u_wb_ack   <= w_u_ack;
      u_wb_err   <= w_u_err;
      o_timeout  <= w_tmo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inner_wb_burst_bridge.sv
// Bench for inner_wb_burst_bridge: behavioural slave plus upstream master,
// expectations from line-wrap arithmetic and response scoreboards.
`default_nettype none

module tb_inner_wb_burst_bridge;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          u_wb_cyc = 0, u_wb_stb = 0, u_wb_we = 0;
  logic [AW-1:0] u_wb_adr = '0;
  logic [DW-1:0] u_wb_o_dat = '0;
  logic [1:0]    u_wb_sel = '0;
  logic          u_wb_4_burst = 0, u_wb_8_burst = 0;
  logic [DW-1:0] u_wb_i_dat;
  logic          u_wb_ack, u_wb_err;
  logic          d_wb_cyc, d_wb_stb, d_wb_we;
  logic [AW-1:0] d_wb_adr;
  logic [DW-1:0] d_wb_o_dat;
  logic [1:0]    d_wb_sel;
  logic [DW-1:0] d_wb_i_dat = '0;
  logic          d_wb_ack = 0, d_wb_err = 0;
  logic          o_timeout;

  inner_wb_burst_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .u_wb_cyc(u_wb_cyc), .u_wb_stb(u_wb_stb), .u_wb_we(u_wb_we),
    .u_wb_adr(u_wb_adr), .u_wb_o_dat(u_wb_o_dat), .u_wb_sel(u_wb_sel),
    .u_wb_4_burst(u_wb_4_burst), .u_wb_8_burst(u_wb_8_burst),
    .u_wb_i_dat(u_wb_i_dat), .u_wb_ack(u_wb_ack), .u_wb_err(u_wb_err),
    .d_wb_cyc(d_wb_cyc), .d_wb_stb(d_wb_stb), .d_wb_we(d_wb_we),
    .d_wb_adr(d_wb_adr), .d_wb_o_dat(d_wb_o_dat), .d_wb_sel(d_wb_sel),
    .d_wb_i_dat(d_wb_i_dat), .d_wb_ack(d_wb_ack), .d_wb_err(d_wb_err),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc_cnt = 0;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] all_out;
  assign all_out = {d_wb_cyc, d_wb_stb, d_wb_we, d_wb_adr, d_wb_o_dat, d_wb_sel,
                    u_wb_i_dat, u_wb_ack, u_wb_err, o_timeout};

  // ---------------- behavioural downstream slave ----------------
  bit            sl_active = 0;
  int            sl_wcnt = 0;
  int            sl_beat = 0;
  int            sl_wait_max = 2;
  int            sl_fixed_wait = -1;
  bit            sl_never = 0;
  int            sl_err_beat = -1;
  bit            sl_use_fixed = 0;
  logic [DW-1:0] sl_fixed_data = '0;
  logic [AW-1:0] q_adr[$];
  logic          q_we[$];
  logic [DW-1:0] q_dat[$];
  logic [1:0]    q_sel[$];
  logic [DW-1:0] sl_rdat[$];
  logic [DW-1:0] up_rdat[$];

  always @(negedge i_clk) begin
    d_wb_ack = 1'b0;
    d_wb_err = 1'b0;
    if (i_rst && d_wb_cyc && d_wb_stb) begin
      if (!sl_active) begin
        sl_active = 1;
        q_adr.push_back(d_wb_adr);
        q_we.push_back(d_wb_we);
        q_dat.push_back(d_wb_o_dat);
        q_sel.push_back(d_wb_sel);
        sl_wcnt = (sl_fixed_wait >= 0) ? sl_fixed_wait : int'($urandom_range(sl_wait_max, 0));
      end
      if (!sl_never) begin
        if (sl_wcnt == 0) begin
          if (sl_beat == sl_err_beat) begin
            d_wb_err = 1'b1;
          end else begin
            d_wb_i_dat = sl_use_fixed ? sl_fixed_data : DW'($urandom);
            d_wb_ack   = 1'b1;
            sl_rdat.push_back(d_wb_i_dat);
          end
          sl_beat++;
          sl_wcnt = -1;
        end else if (sl_wcnt > 0) begin
          sl_wcnt--;
        end
      end
    end else begin
      sl_active = 0;
    end
  end

  // ---------------- upstream master + reference model ----------------
  logic [DW-1:0] wq[8];
  logic [1:0]    wsel[8];
  int b_ack, b_err, b_cyclow, b_lat, b_stb_cyc, b_err_cyc, b_iters;
  bit b_tmo;

  function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] base, input int n, input int i);
    int b, off;
    b   = int'(base);
    off = b % n;
    return AW'(b - off + ((off + i) % n));
  endfunction

  task automatic reset_queues();
    q_adr.delete(); q_we.delete(); q_dat.delete(); q_sel.delete();
    sl_rdat.delete(); up_rdat.delete();
    sl_beat = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      wq[i]   = DW'($urandom);
      wsel[i] = 2'($urandom);
    end
  endtask

  task automatic do_burst(input bit we, input bit t4, input bit t8,
                          input logic [AW-1:0] base, input int drop_after);
    int n, i, budget;
    bit started, done;
    n = t8 ? 8 : (t4 ? 4 : 1);
    i = 0; budget = 0; started = 0; done = 0;
    b_ack = 0; b_err = 0; b_cyclow = 0; b_lat = -1; b_stb_cyc = -1; b_err_cyc = -1; b_tmo = 0;
    u_wb_cyc = 1; u_wb_stb = 1; u_wb_we = we; u_wb_adr = base;
    u_wb_4_burst = t4; u_wb_8_burst = t8; u_wb_o_dat = wq[0]; u_wb_sel = wsel[0];
    while (!done && budget < 300) begin
      @(negedge i_clk);
      budget++;
      if (d_wb_stb && !started) begin
        started = 1; b_lat = budget; b_stb_cyc = cyc_cnt;
      end
      if (started && !d_wb_cyc && !u_wb_err) b_cyclow++;
      if (u_wb_ack) begin
        b_ack++;
        up_rdat.push_back(u_wb_i_dat);
        i++;
        if (i >= n) done = 1;
        else begin
          u_wb_o_dat = wq[i];
          u_wb_sel   = wsel[i];
        end
      end
      if (u_wb_err) begin
        b_err++; b_err_cyc = cyc_cnt; b_tmo = o_timeout; done = 1;
      end
      if (!done && drop_after >= 0 && b_ack == drop_after && d_wb_stb) done = 1;
    end
    b_iters = budget;
    u_wb_cyc = 0; u_wb_stb = 0; u_wb_4_burst = 0; u_wb_8_burst = 0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL burst_budget: burst at %h not finished after %0d cycles (acks %0d, required %0d)",
               base, budget, b_ack, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    #2 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if (all_out !== 64'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_single_read();
    reset_queues(); fill_random();
    sl_fixed_wait = 2; sl_use_fixed = 1; sl_fixed_data = 16'hBEEF;
    do_burst(0, 0, 0, 24'h000100, -1);
    n_cmp++; if (b_ack !== 1) begin n_bad++; $display("FAIL single_acks: got %0d required 1", b_ack); end
    n_cmp++; if (up_rdat.size() != 1 || up_rdat[0] !== 16'hBEEF) begin
      n_bad++; $display("FAIL single_rdata: got %h required beef", (up_rdat.size() > 0) ? up_rdat[0] : 16'hxxxx); end
    n_cmp++; if (q_adr.size() != 1 || q_adr[0] !== 24'h000100) begin
      n_bad++; $display("FAIL single_adr: %0d beats, first %h required 1 beat at 000100", q_adr.size(), (q_adr.size() > 0) ? q_adr[0] : 24'hx); end
    n_cmp++; if (b_lat !== 1) begin n_bad++; $display("FAIL single_stb_latency: got %0d required 1", b_lat); end
    @(negedge i_clk);
    n_cmp++; if (d_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL single_cyc_after: got %b required 0", d_wb_cyc); end
    sl_fixed_wait = -1; sl_use_fixed = 0;
  endtask

  task automatic test_read4();
    reset_queues(); fill_random();
    do_burst(0, 1, 0, 24'h000013, -1);
    n_cmp++; if (b_ack !== 4) begin n_bad++; $display("FAIL r4_acks: got %0d required 4", b_ack); end
    n_cmp++; if (b_cyclow !== 0) begin n_bad++; $display("FAIL r4_cyc_locked: cyc low %0d cycles required 0", b_cyclow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_adr.size() <= i || q_adr[i] !== exp_adr(24'h13, 4, i)) begin
        n_bad++; $display("FAIL r4_adr[%0d]: got %h required %h", i, (q_adr.size() > i) ? q_adr[i] : 24'hx, exp_adr(24'h13, 4, i));
      end
      n_cmp++;
      if (up_rdat.size() <= i || sl_rdat.size() <= i || up_rdat[i] !== sl_rdat[i]) begin
        n_bad++; $display("FAIL r4_rdata[%0d]: got %h required %h", i, (up_rdat.size() > i) ? up_rdat[i] : 16'hx, (sl_rdat.size() > i) ? sl_rdat[i] : 16'hx);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_write8();
    reset_queues(); fill_random();
    for (int i = 0; i < 8; i++) wq[i] = DW'(16'h1000 + i);
    sl_fixed_wait = 0;
    do_burst(1, 1, 1, 24'h000025, -1);
    n_cmp++; if (b_ack !== 8) begin n_bad++; $display("FAIL w8_acks: got %0d required 8", b_ack); end
    n_cmp++; if (q_adr.size() != 8) begin n_bad++; $display("FAIL w8_beats: got %0d required 8", q_adr.size()); end
    n_cmp++; if (b_iters !== 16) begin n_bad++; $display("FAIL w8_zero_wait_cycles: got %0d required 16", b_iters); end
    for (int i = 0; i < 8 && i < q_adr.size(); i++) begin
      n_cmp++;
      if (q_adr[i] !== exp_adr(24'h25, 8, i) || q_dat[i] !== DW'(16'h1000 + i) || q_we[i] !== 1'b1 || q_sel[i] !== wsel[i]) begin
        n_bad++; $display("FAIL w8_beat[%0d]: got adr %h dat %h we %b sel %b required adr %h dat %h we 1 sel %b",
                          i, q_adr[i], q_dat[i], q_we[i], q_sel[i], exp_adr(24'h25, 8, i), DW'(16'h1000 + i), wsel[i]);
      end
    end
    sl_fixed_wait = -1;
    @(negedge i_clk);
  endtask

  task automatic test_timeout();
    reset_queues(); fill_random();
    sl_never = 1;
    do_burst(0, 1, 0, 24'h000040, -1);
    n_cmp++; if (b_err !== 1 || b_ack !== 0) begin n_bad++; $display("FAIL tmo_resp: got err %0d ack %0d required err 1 ack 0", b_err, b_ack); end
    n_cmp++; if (b_err_cyc - b_stb_cyc !== TMO + 1) begin
      n_bad++; $display("FAIL tmo_delay: got %0d required %0d", b_err_cyc - b_stb_cyc, TMO + 1); end
    n_cmp++; if (b_tmo !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b required 1", b_tmo); end
    sl_never = 0;
    @(negedge i_clk);
    n_cmp++; if ({d_wb_cyc, o_timeout, u_wb_err} !== 3'b000) begin
      n_bad++; $display("FAIL tmo_after: cyc/tmo/err got %b required 000", {d_wb_cyc, o_timeout, u_wb_err}); end
    reset_queues();
    do_burst(0, 0, 0, 24'h000200, -1);
    n_cmp++; if (b_ack !== 1) begin n_bad++; $display("FAIL tmo_recover: acks %0d required 1", b_ack); end
    @(negedge i_clk);
  endtask

  task automatic test_err_beat();
    reset_queues(); fill_random();
    sl_err_beat = 2;
    do_burst(0, 1, 0, 24'h000031, -1);
    n_cmp++; if (b_ack !== 2 || b_err !== 1) begin n_bad++; $display("FAIL err_resp: got ack %0d err %0d required 2/1", b_ack, b_err); end
    n_cmp++; if (b_tmo !== 1'b0) begin n_bad++; $display("FAIL err_tmo_flag: got %b required 0", b_tmo); end
    repeat (4) @(negedge i_clk);
    n_cmp++; if (q_adr.size() != 3) begin n_bad++; $display("FAIL err_beats: got %0d required 3", q_adr.size()); end
    sl_err_beat = -1;
  endtask

  task automatic test_cyc_drop();
    int spur;
    reset_queues(); fill_random();
    sl_fixed_wait = 0;
    do_burst(0, 0, 1, 24'h000058, 2);
    @(negedge i_clk);
    n_cmp++; if ({d_wb_cyc, d_wb_stb, u_wb_ack, u_wb_err} !== 4'b0000) begin
      n_bad++; $display("FAIL drop_outputs: cyc/stb/ack/err got %b required 0000", {d_wb_cyc, d_wb_stb, u_wb_ack, u_wb_err}); end
    spur = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (u_wb_ack || u_wb_err || d_wb_cyc) spur++;
    end
    n_cmp++; if (spur !== 0) begin n_bad++; $display("FAIL drop_quiet: got %0d active cycles required 0", spur); end
    sl_fixed_wait = -1;
  endtask

  task automatic test_reset_mid();
    reset_queues(); fill_random();
    sl_never = 1;
    u_wb_cyc = 1; u_wb_stb = 1; u_wb_we = 1; u_wb_adr = 24'h000777;
    u_wb_o_dat = 16'h5A5A; u_wb_sel = 2'b11;
    repeat (2) @(negedge i_clk);
    n_cmp++; if (d_wb_stb !== 1'b1) begin n_bad++; $display("FAIL rstmid_issue: stb got %b required 1", d_wb_stb); end
    i_rst = 1'b0;
    #1;
    n_cmp++; if (all_out !== 64'd0) begin n_bad++; $display("FAIL rstmid_outputs: got %h required 0", all_out); end
    u_wb_cyc = 0; u_wb_stb = 0; u_wb_we = 0;
    @(negedge i_clk);
    i_rst = 1'b1; sl_never = 0;
    @(negedge i_clk);
    reset_queues();
    do_burst(0, 0, 0, 24'h000300, -1);
    n_cmp++; if (b_ack !== 1) begin n_bad++; $display("FAIL rstmid_recover: acks %0d required 1", b_ack); end
    @(negedge i_clk);
  endtask

  task automatic test_random();
    bit we, t4, t8;
    int n;
    logic [AW-1:0] base;
    for (int k = 0; k < 20; k++) begin
      reset_queues(); fill_random();
      we = 1'($urandom); t4 = 1'($urandom); t8 = 1'($urandom);
      base = AW'($urandom);
      n = t8 ? 8 : (t4 ? 4 : 1);
      do_burst(we, t4, t8, base, -1);
      n_cmp++;
      if (b_ack !== n || b_err !== 0 || b_cyclow !== 0 || q_adr.size() != n) begin
        n_bad++; $display("FAIL rnd%0d_shape: got acks %0d err %0d cyclow %0d beats %0d required %0d/0/0/%0d",
                          k, b_ack, b_err, b_cyclow, q_adr.size(), n, n);
      end
      for (int i = 0; i < n && i < q_adr.size() && i < up_rdat.size(); i++) begin
        n_cmp++;
        if (q_adr[i] !== exp_adr(base, n, i) || q_we[i] !== we || q_sel[i] !== wsel[i] ||
            (we && q_dat[i] !== wq[i]) || (!we && up_rdat[i] !== sl_rdat[i])) begin
          n_bad++; $display("FAIL rnd%0d_beat%0d: got adr %h we %b sel %b wdat %h rdat %h required adr %h we %b sel %b wdat %h rdat %h",
                            k, i, q_adr[i], q_we[i], q_sel[i], q_dat[i], up_rdat[i],
                            exp_adr(base, n, i), we, wsel[i], wq[i], sl_rdat[i]);
        end
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_back_to_back();
    reset_queues(); fill_random();
    do_burst(1, 1, 0, 24'h0000A6, -1);
    n_cmp++; if (b_ack !== 4 || b_lat !== 1) begin n_bad++; $display("FAIL b2b_first: acks %0d lat %0d required 4/1", b_ack, b_lat); end
    reset_queues();
    do_burst(0, 1, 0, 24'h0000B1, -1);
    n_cmp++; if (b_ack !== 4 || b_lat !== 2) begin n_bad++; $display("FAIL b2b_second: acks %0d lat %0d required 4/2", b_ack, b_lat); end
    n_cmp++; if (q_adr.size() != 4 || q_adr[0] !== 24'h0000B1 || q_adr[3] !== 24'h0000B0) begin
      n_bad++; $display("FAIL b2b_adr: %0d beats first %h last %h required 4 beats b1..b0", q_adr.size(),
                        (q_adr.size() > 0) ? q_adr[0] : 24'hx, (q_adr.size() > 3) ? q_adr[3] : 24'hx); end
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read4();
    test_write8();
    test_timeout();
    test_err_beat();
    test_cyc_drop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (%0d compared, %0d mismatched)", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
